// File: rtl/img_pkg.sv
// img_pkg: shared pixel width, default frame geometry and counter-width helper
package img_pkg;
    localparam int PIXEL_W = 8;
    localparam int DEF_PIC_WIDTH = 250;
    localparam int DEF_PIC_HEIGHT = 250;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/line_ram.sv
// line_ram: single-port row memory, read-before-write with asynchronous read
module line_ram
    import img_pkg::*;
#(
    parameter int DEPTH = DEF_PIC_WIDTH,
    parameter int WIDTH = PIXEL_W
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    assign rdata = mem[addr];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
endmodule

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: three-row line buffer presenting one column of rows r-2, r-1, r
module sobel_line_buffer
    import img_pkg::*;
#(
    parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEF_PIC_HEIGHT,
    parameter int WIDTH      = PIXEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             sof_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             frame_end
);
    localparam int CW = clog2(PIC_WIDTH);
    localparam int RW = clog2(PIC_HEIGHT);
    logic [CW-1:0]    col_cnt, addr;
    logic [RW-1:0]    row_cnt;
    logic [WIDTH-1:0] rd_a, rd_b;
    logic             last_col, last_row;
    assign addr     = sof_in ? '0 : col_cnt;
    assign last_col = col_cnt == CW'(PIC_WIDTH - 1);
    assign last_row = row_cnt == RW'(PIC_HEIGHT - 1);
    line_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH)) u_ram_a (
        .clk(clk), .we(valid_in), .addr(addr), .wdata(din), .rdata(rd_a)
    );
    line_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH)) u_ram_b (
        .clk(clk), .we(valid_in), .addr(addr), .wdata(rd_a), .rdata(rd_b)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            valid_out <= 1'b0;
            frame_end <= 1'b0;
            dout1     <= '0;
            dout2     <= '0;
            dout3     <= '0;
        end else begin
            valid_out <= valid_in && !sof_in && row_cnt >= RW'(2);
            frame_end <= valid_in && !sof_in && last_col && last_row;
            if (valid_in) begin
                dout1   <= rd_b;
                dout2   <= rd_a;
                dout3   <= din;
                col_cnt <= sof_in ? CW'(1) : last_col ? '0 : col_cnt + CW'(1);
                row_cnt <= sof_in ? '0 : !last_col ? row_cnt : last_row ? '0 : row_cnt + RW'(1);
            end
        end
    end
endmodule

// File: doc/sobel_line_buffer.md
Name: sobel_line_buffer

Overview:
- Three-row line buffer that sits directly upstream of the 3x3 Sobel window stage.
- Accepts a raster-order 8-bit grey pixel stream, one pixel per valid_in cycle.
- Presents the same column of three vertically adjacent rows in parallel: dout1 = row r-2 (top), dout2 = row r-1, dout3 = row r (bottom).
- Its outputs connect straight to the Sobel stage's din1/din2/din3/valid_in.

Parameters:
PIC_WIDTH, 250, pixels per row (>=3)
PIC_HEIGHT, 250, rows per frame (>=3)
WIDTH, 8, pixel data width

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
valid_in  input  1  input pixel qualifier; gaps allowed anywhere
sof_in  input  1  start-of-frame marker, sampled only when valid_in=1
din  input  WIDTH  input pixel
valid_out  output  1  output column qualifier
dout1  output  WIDTH  pixel from row r-2 (top row of window)
dout2  output  WIDTH  pixel from row r-1 (middle row)
dout3  output  WIDTH  pixel from row r (bottom row, current)
frame_end  output  1  one-cycle pulse coincident with valid_out for last pixel of frame

Behaviour:
- Reset (rst=1 at clk edge):
  - col_cnt=0, row_cnt=0.
  - valid_out=0, frame_end=0, dout1/2/3=0.
  - Row memories are not cleared; their contents are don't-care because output is gated by row_cnt.
- Storage: two row memories, ram_a (row r-1) and ram_b (row r-2), each PIC_WIDTH x WIDTH, addressed by col_cnt.
- Accepted pixel (valid_in=1), at col_cnt=c, on the same edge:
  - dout3<=din, dout2<=ram_a[c], dout1<=ram_b[c].
  - ram_b[c]<=ram_a[c], ram_a[c]<=din.
  - Read-before-write: outputs carry the old contents.
- Latency: exactly 1 cycle from accepted input to valid_out.
- valid_out<=valid_in AND (row_cnt>=2), evaluated with pre-update row_cnt, so the first two rows of every frame produce no output.
- valid_in=0: counters, memories and dout1/2/3 hold; valid_out<=0 and frame_end<=0 next cycle. Stalls of any length are lossless.
- Counters, advanced only on accepted pixels:
  - col_cnt wraps PIC_WIDTH-1 -> 0 and then increments row_cnt.
  - row_cnt wraps PIC_HEIGHT-1 -> 0 on the last pixel of the frame.
  - Widths are $clog2(PIC_WIDTH) and $clog2(PIC_HEIGHT).
- frame_end<=1 when the accepted pixel has col_cnt=PIC_WIDTH-1 and row_cnt=PIC_HEIGHT-1; otherwise 0.
- sof_in=1 with valid_in=1:
  - The pixel is treated as col 0, row 0 regardless of counter state, and is written to ram_a[0].
  - Counters go to col 1, row 0.
  - valid_out for this pixel is 0.
  - This resynchronises after truncated frames. sof_in with valid_in=0 is ignored.
- Rows 0 and 1 of a new frame overwrite the memories; stale data from the previous frame never reaches a valid_out=1 cycle.
- Reset asserted mid-frame: the next accepted pixel is row 0, col 0; no output until two full rows are accepted.
- No backpressure: the downstream stage always accepts.
- Output stream per frame: (PIC_HEIGHT-2) x PIC_WIDTH valid columns. Horizontal window formation and row-boundary masking stay downstream.

Decomposition:
- Shared package (img_pkg): PIXEL_W=8, default PIC_WIDTH/PIC_HEIGHT, the function clog2 for counter widths.
- Sub-module line_ram: single-port, depth PIC_WIDTH, synchronous write with read-before-write (read of old data on the same address/cycle). It is instantiated twice (ram_a, ram_b) and must infer block or distributed RAM.
- Top holds counters, output registers and control.

Test Plan:
All scenarios use PIC_WIDTH=4 and PIC_HEIGHT=4 unless noted, with pixel value = row*16+col.
1. Continuous frame, valid_in=1 for 16 cycles:
   - valid_out=0 for the first 8 pixels.
   - Input 0x20 -> next cycle dout1=0x00, dout2=0x10, dout3=0x20, valid_out=1.
   - Input 0x33 -> dout=0x13/0x23/0x33 with frame_end=1.
   - Exactly 8 valid_out cycles in total.
2. Same frame with valid_in toggled 1/0 and one 5-cycle gap mid-row 2:
   - Identical sequence of valid outputs.
   - dout held and valid_out=0 during gaps.
3. Two back-to-back frames, second frame pixel = 0x80 + row*16+col:
   - No valid_out during frame 2 rows 0-1.
   - First frame-2 output = 0x80/0x90/0xA0.
4. rst pulsed for 1 cycle after pixel 0x21:
   - Outputs zero next cycle.
   - Subsequent pixels restart at row 0; first valid_out after 8 more accepted pixels.
5. sof_in asserted on the 3rd pixel of row 1:
   - That pixel becomes row 0, col 0.
   - valid_out first reappears 8 accepted pixels after it.
   - Output data matches the re-aligned rows.
6. PIC_WIDTH=250, random pixels, full 250x250 frame:
   - Compare every valid column against a software model.
   - 248x250 valid outputs, single frame_end.
